// File: rtl/life_ctrl.sv
// life_ctrl: sequencer for the game-of-life torus array.
// Loads a pattern serially, paces generations (free-run or single-step),
// gates each step on step_allow, and counts live cells by recirculating
// the torus shift chain.
// Optional feature macro: LIFE_LFSR_SEED_EN (internal 16-bit LFSR seed source).
module life_ctrl #(
  parameter int TORUS_WIDTH  = 32,
  parameter int TORUS_HEIGHT = 16,
  parameter int PERIOD_W     = 24,
  parameter int GEN_W        = 16,
  localparam int N           = TORUS_WIDTH * TORUS_HEIGHT,
  localparam int POP_W       = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_load,
  input  logic                cmd_count,
  input  logic                cmd_run,
  input  logic                cmd_pause,
  input  logic                cmd_step,
  input  logic [PERIOD_W-1:0] step_period,
  input  logic                step_allow,
  input  logic                ext_seed,
  input  logic                ext_valid,
  output logic                ext_ready,
  input  logic                load_src,
  input  logic [15:0]         lfsr_seed,
  input  logic                torus_last,
  output logic                seed,
  output logic                seed_ena,
  output logic                life_step,
  output logic [GEN_W-1:0]    generation,
  output logic [POP_W-1:0]    population,
  output logic [1:0]          state,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_COUNT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  state_t              ret_q, ret_d;
  logic [POP_W-1:0]    bits_q, bits_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic [PERIOD_W-1:0] reload;
  logic                pending_q, pending_d;
  logic                seed_q, seed_d;
  logic                seed_ena_q, seed_ena_d;
  logic                life_step_q, life_step_d;
  logic                ext_ready_q, ext_ready_d;
  logic                busy_q, busy_d;
  logic [GEN_W-1:0]    gen_q, gen_d;
  logic [POP_W-1:0]    pop_q, pop_d;
  logic [POP_W-1:0]    acc_q, acc_d;

  logic                issue, set_step, tick_run, shift;
  logic                lfsr_load, lfsr_adv;
  logic                load_src_eff, src_lfsr, lfsr_bit;

  assign reload = (step_period == '0) ? '0 : step_period - PERIOD_W'(1);

`ifdef LIFE_LFSR_SEED_EN
  logic [15:0] lfsr_q;
  logic        src_lfsr_q;
  logic        lfsr_fb;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting right
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // LFSR state and the source selection captured with cmd_load
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q     <= '0;
      src_lfsr_q <= 1'b0;
    end else if (lfsr_load) begin
      lfsr_q     <= (lfsr_seed == '0) ? 16'hACE1 : lfsr_seed;
      src_lfsr_q <= load_src;
    end else if (lfsr_adv) begin
      lfsr_q     <= {lfsr_fb, lfsr_q[15:1]};
    end
  end

  assign load_src_eff = load_src;
  assign src_lfsr     = src_lfsr_q;
  assign lfsr_bit     = lfsr_q[0];
`else
  logic unused_lfsr;
  assign load_src_eff = 1'b0;
  assign src_lfsr     = 1'b0;
  assign lfsr_bit     = 1'b0;
  assign unused_lfsr  = ^{load_src, lfsr_seed, lfsr_load, lfsr_adv};
`endif

  // Next-state, command arbitration, step pacing and shift control
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    bits_d      = bits_q;
    pcnt_d      = pcnt_q;
    pending_d   = pending_q;
    seed_d      = seed_q;
    seed_ena_d  = 1'b0;
    life_step_d = 1'b0;
    ext_ready_d = ext_ready_q;
    gen_d       = gen_q;
    pop_d       = pop_q;
    acc_d       = acc_q;
    issue       = 1'b0;
    set_step    = 1'b0;
    tick_run    = 1'b0;
    shift       = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;

    unique case (state_q)
      ST_PAUSE, ST_RUN: begin
        if (cmd_load) begin
          state_d     = ST_LOAD;
          bits_d      = POP_W'(N);
          lfsr_load   = 1'b1;
          ext_ready_d = ~load_src_eff;
        end else if (cmd_count) begin
          state_d    = ST_COUNT;
          ret_d      = state_q;
          bits_d     = POP_W'(N);
          acc_d      = '0;
          seed_ena_d = 1'b1;
        end else begin
          if (cmd_pause) begin
            state_d = ST_PAUSE;
          end else if (cmd_run) begin
            if (state_q == ST_PAUSE) begin
              state_d = ST_RUN;
              pcnt_d  = reload;
            end
          end else if (cmd_step && state_q == ST_PAUSE) begin
            set_step = 1'b1;
          end

          // A cmd_run that lands while already running leaves the period alone
          tick_run = (state_q == ST_RUN) && !cmd_pause;
          if (tick_run) begin
            if (pcnt_q == '0) begin
              set_step = 1'b1;
              pcnt_d   = reload;
            end else begin
              pcnt_d   = pcnt_q - PERIOD_W'(1);
            end
          end

          issue       = pending_q & step_allow;
          life_step_d = issue;
          if (issue) gen_d = gen_q + GEN_W'(1);
          // Issue and a fresh expiry in one cycle leave exactly one pending
          pending_d = (pending_q & ~issue) | set_step;
        end
      end

      ST_LOAD: begin
        if (src_lfsr) begin
          shift    = 1'b1;
          seed_d   = lfsr_bit;
          lfsr_adv = 1'b1;
        end else if (ext_valid && ext_ready_q) begin
          shift  = 1'b1;
          seed_d = ext_seed;
        end
        if (shift) begin
          seed_ena_d = 1'b1;
          bits_d     = bits_q - POP_W'(1);
          if (bits_q == POP_W'(1)) begin
            state_d     = ST_PAUSE;
            ext_ready_d = 1'b0;
            gen_d       = '0;
            pending_d   = 1'b0;
            pcnt_d      = '0;
          end
        end
      end

      ST_COUNT: begin
        acc_d  = acc_q + POP_W'(torus_last);
        bits_d = bits_q - POP_W'(1);
        if (bits_q == POP_W'(1)) begin
          state_d = ret_q;
          pop_d   = acc_d;
        end else begin
          seed_ena_d = 1'b1;
        end
      end
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_COUNT);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_PAUSE;
      ret_q       <= ST_PAUSE;
      bits_q      <= '0;
      pcnt_q      <= '0;
      pending_q   <= 1'b0;
      seed_q      <= 1'b0;
      seed_ena_q  <= 1'b0;
      life_step_q <= 1'b0;
      ext_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      gen_q       <= '0;
      pop_q       <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      bits_q      <= bits_d;
      pcnt_q      <= pcnt_d;
      pending_q   <= pending_d;
      seed_q      <= seed_d;
      seed_ena_q  <= seed_ena_d;
      life_step_q <= life_step_d;
      ext_ready_q <= ext_ready_d;
      busy_q      <= busy_d;
      gen_q       <= gen_d;
      pop_q       <= pop_d;
      acc_q       <= acc_d;
    end
  end

  // During COUNT the torus output feeds straight back into cell (0,0): a
  // registered copy would add a bit to the loop and N shifts would no longer
  // restore the pattern. The select itself is the registered state.
  assign seed       = (state_q == ST_COUNT) ? torus_last : seed_q;
  assign seed_ena   = seed_ena_q;
  assign life_step  = life_step_q;
  assign ext_ready  = ext_ready_q;
  assign busy       = busy_q;
  assign generation = gen_q;
  assign population = pop_q;
  assign state      = state_q;

endmodule
